// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a hardware clear sequence.
// After reset a CLEAR sequence zeroes every register, one per cycle, before
// user writes are accepted. Register 0 always reads as zero.
// Optional feature macro: REGFILE_BYPASS_EN (write-through from wd to any read
// port addressing the register being written in the same cycle).
module regfile_mp #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_RD     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          wa,
    input  logic [DATA_WIDTH-1:0]          wd,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   ra,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd,
    output logic [DATA_WIDTH-1:0]          a0,
    output logic                           busy
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned A0_IDX = 10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    mem_we_c;
    logic [ADDR_WIDTH-1:0]   mem_wa_c;
    logic [DATA_WIDTH-1:0]   mem_wd_c;
    logic                    rd_en_c;

    // State and clear-counter register; reset restarts the clear at entry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: walk cnt through every entry, then park in READY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            default: ;
        endcase
    end

    // Outputs: array write port select, busy flag, read enable
    always_comb begin
        busy     = 1'b1;
        rd_en_c  = 1'b0;
        mem_we_c = 1'b0;
        mem_wa_c = cnt_q;
        mem_wd_c = '0;
        if (!rst) begin
            case (state_q)
                ST_CLEAR: begin
                    mem_we_c = 1'b1;
                end
                ST_READY: begin
                    busy    = 1'b0;
                    rd_en_c = 1'b1;
                    if (we && (wa != '0)) begin
                        mem_we_c = 1'b1;
                        mem_wa_c = wa;
                        mem_wd_c = wd;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register array: single write port shared by clear sequence and user
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_wa_c] <= mem_wd_c;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra_k;
        logic [DATA_WIDTH-1:0] rd_k;

        assign ra_k = ra[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Zero-latency read; register 0 and the clear phase force zero
        always_comb begin
            rd_k = mem_q[ra_k];
`ifdef REGFILE_BYPASS_EN
            if (rd_en_c && mem_we_c && (ra_k == wa)) begin
                rd_k = wd;
            end
`endif
            if (!rd_en_c || (ra_k == '0)) begin
                rd_k = '0;
            end
        end

        assign rd[k*DATA_WIDTH +: DATA_WIDTH] = rd_k;
    end

    // Debug view of register 10: committed contents only, never bypassed
    if (DEPTH > A0_IDX) begin : g_a0
        assign a0 = rd_en_c ? mem_q[ADDR_WIDTH'(A0_IDX)] : '0;
    end else begin : g_no_a0
        assign a0 = '0;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 5/32/2 instance plus a 3/32/4 instance.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    // instance 1: ADDR_WIDTH=5, NUM_RD=2
    logic        rst, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [31:0] a0;
    logic        busy;
    // instance 2: ADDR_WIDTH=3, NUM_RD=4
    logic        rst2, we2;
    logic [2:0]  wa2;
    logic [31:0] wd2;
    logic [11:0] ra2;
    logic [127:0] rd2;
    logic [31:0] a0_2;
    logic        busy2;

    int checks   = 0;
    int failures = 0;

    regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2)) u_dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra(ra), .rd(rd), .a0(a0), .busy(busy)
    );

    regfile_mp #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .NUM_RD(4)) u_dut4 (
        .clk(clk), .rst(rst2), .we(we2), .wa(wa2), .wd(wd2),
        .ra(ra2), .rd(rd2), .a0(a0_2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
        rst2 = 1'b1; we2 = 1'b0; wa2 = '0; wd2 = '0; ra2 = '0;

        // reset held for two cycles
        tick();
        tick();
        ra = {5'd10, 5'd3};
        #1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rd0", rd[31:0], 32'h0);
        check("rst_rd1", rd[63:32], 32'h0);
        check("rst_a0", a0, 32'h0);

        // release: busy must last exactly 32 cycles
        rst = 1'b0;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n == 5) begin
                check("clear_rd0", rd[31:0], 32'h0);
                check("clear_a0", a0, 32'h0);
            end
            n++;
            tick();
        end
        check("clear_len", 32'(n), 32'd32);
        check("ready_busy", 32'(busy), 32'd0);

        // every register reads zero after clear
        for (int i = 0; i < 32; i++) begin
            ra = {5'(31 - i), 5'(i)};
            #1;
            check($sformatf("zero_p0_r%0d", i), rd[31:0], 32'h0);
            check($sformatf("zero_p1_r%0d", 31 - i), rd[63:32], 32'h0);
        end

        // write reg 10, both ports on 10, a0 updates after the edge
        we = 1'b1; wa = 5'd10; wd = 32'hDEADBEEF; ra = {5'd10, 5'd10};
        #1;
        check("a0_pre", a0, 32'h0);
        check("r10_p0_same", rd[31:0], BYP ? 32'hDEADBEEF : 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("a0_post", a0, 32'hDEADBEEF);
        check("r10_p0", rd[31:0], 32'hDEADBEEF);
        check("r10_p1", rd[63:32], 32'hDEADBEEF);

        // writes to reg 0 are discarded and never bypassed
        we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra = {5'd0, 5'd0};
        #1;
        check("r0_same", rd[31:0], 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("r0_next", rd[31:0], 32'h0);
        check("r0_p1_next", rd[63:32], 32'h0);

        // write reg 7 while port 1 reads it
        we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra = {5'd7, 5'd10};
        #1;
        check("r7_same", rd[63:32], BYP ? 32'hA5A5A5A5 : 32'h0);
        check("a0_nobyp", a0, 32'hDEADBEEF);
        tick();
        we = 1'b0;
        #1;
        check("r7_next", rd[63:32], 32'hA5A5A5A5);
        check("r10_kept", rd[31:0], 32'hDEADBEEF);

        // reset in READY with a simultaneous write
        rst = 1'b1; we = 1'b1; wa = 5'd7; wd = 32'hFFFFFFFF;
        #1;
        check("rst_ready_busy", 32'(busy), 32'd1);
        check("rst_ready_rd1", rd[63:32], 32'h0);
        check("rst_ready_a0", a0, 32'h0);
        tick();
        rst = 1'b0; we = 1'b0;
        // run 10 cycles of CLEAR, then reset again mid-sequence
        for (int i = 0; i < 10; i++) tick();
        check("mid_clear_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n == 3) begin
                we = 1'b1; wa = 5'd5; wd = 32'h1;
            end else begin
                we = 1'b0;
            end
            n++;
            tick();
        end
        we = 1'b0;
        check("restart_len", 32'(n), 32'd32);
        ra = {5'd7, 5'd5};
        #1;
        check("r5_clear_write", rd[31:0], 32'h0);
        check("r7_recleared", rd[63:32], 32'h0);
        check("a0_recleared", a0, 32'h0);

        // 4-port, 8-entry instance
        rst2 = 1'b0;
        #1;
        n = 0;
        while (busy2 === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("d4_clear_len", 32'(n), 32'd8);
        for (int i = 1; i <= 4; i++) begin
            we2 = 1'b1; wa2 = 3'(i); wd2 = 32'(i * 32'h11);
            tick();
        end
        we2 = 1'b0;
        ra2 = {3'd4, 3'd3, 3'd2, 3'd1};
        #1;
        check("d4_p0", rd2[31:0],   32'h11);
        check("d4_p1", rd2[63:32],  32'h22);
        check("d4_p2", rd2[95:64],  32'h33);
        check("d4_p3", rd2[127:96], 32'h44);
        check("d4_a0", a0_2, 32'h0);
        ra2 = {3'd3, 3'd3, 3'd3, 3'd3};
        #1;
        check("d4_same_p0", rd2[31:0],   32'h33);
        check("d4_same_p3", rd2[127:96], 32'h33);
        ra2 = {3'd0, 3'd0, 3'd7, 3'd5};
        #1;
        check("d4_r5", rd2[31:0], 32'h0);
        check("d4_r0", rd2[127:96], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
